// File: rtl/delivery_game_pkg.sv
//==============================================================================
// Module : delivery_game_pkg
// Brief  : State codes, control-word layout and defaults for the game control unit
// Rev    : 1.0
//==============================================================================
`default_nettype none

package delivery_game_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        PEDE    = 4'd2,
        ESPERA  = 4'd3,
        JOGA    = 4'd4,
        FALHA   = 4'd5,
        FIM     = 4'd6,
        PAUSA   = 4'd7
    } state_t;

    localparam int C_MAX_RETRIES = 3;
    localparam int C_RETRY_W     = 4;

    typedef struct packed {
        logic zera_fd;
        logic reset_ultrasonico;
        logic get_velocity;
        logic count_map;
        logic reset_delay;
        logic conta_delay;
        logic reset_timeout;
        logic conta_timeout;
        logic jogando;
        logic fim_jogo;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            PREPARA: begin
                c.zera_fd           = 1'b1;
                c.reset_ultrasonico = 1'b1;
                c.reset_delay       = 1'b1;
                c.reset_timeout     = 1'b1;
            end
            PEDE: begin
                c.get_velocity  = 1'b1;
                c.reset_timeout = 1'b1;
                c.reset_delay   = 1'b1;
                c.count_map     = 1'b1;
                c.jogando       = 1'b1;
            end
            ESPERA: begin
                c.conta_timeout = 1'b1;
                c.count_map     = 1'b1;
                c.jogando       = 1'b1;
            end
            FALHA: begin
                c.reset_ultrasonico = 1'b1;
                c.count_map         = 1'b1;
                c.jogando           = 1'b1;
            end
            JOGA: begin
                c.count_map   = 1'b1;
                c.conta_delay = 1'b1;
                c.jogando     = 1'b1;
            end
            FIM:     c.fim_jogo = 1'b1;
            PAUSA:   c.jogando  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/delivery_game_uc_if.sv
//==============================================================================
// Module : delivery_game_uc_if
// Brief  : Control/status bundle between the game control unit and its datapath
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface delivery_game_uc_if;
    logic       game_over;
    logic       velocity_ready;
    logic       velocity_timeout;
    logic       end_delay;
    logic       zera_fd;
    logic       reset_ultrasonico;
    logic       get_velocity;
    logic       count_map;
    logic       reset_delay;
    logic       conta_delay;
    logic       reset_timeout;
    logic       conta_timeout;
    logic       jogando;
    logic       fim_jogo;
    logic       falha_sensor;
    logic [3:0] db_estado;

    modport master (
        input  game_over, velocity_ready, velocity_timeout, end_delay,
        output zera_fd, reset_ultrasonico, get_velocity, count_map,
               reset_delay, conta_delay, reset_timeout, conta_timeout,
               jogando, fim_jogo, falha_sensor, db_estado
    );

    modport slave (
        output game_over, velocity_ready, velocity_timeout, end_delay,
        input  zera_fd, reset_ultrasonico, get_velocity, count_map,
               reset_delay, conta_delay, reset_timeout, conta_timeout,
               jogando, fim_jogo, falha_sensor, db_estado
    );
endinterface

`default_nettype wire

// File: rtl/delivery_game_uc_edge_detector.sv
//==============================================================================
// Module : edge_detector
// Brief  : One-cycle pulse on a 0->1 transition of a level input
// Rev    : 1.0
//==============================================================================
`default_nettype none

module edge_detector (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic sinal,
    output logic      pulso
);
    logic r_sinal_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sinal_d <= 1'b0;
        else        r_sinal_d <= sinal;
    end

    assign pulso = sinal & ~r_sinal_d;
endmodule

`default_nettype wire

// File: rtl/delivery_game_uc.sv
//==============================================================================
// Module : delivery_game_uc
// Brief  : Moore control unit for the delivery game (start, sensor retry, collision)
// Config : DELIVERY_GAME_PAUSE_EN enables the PAUSA state driven by 'pausa'
// Rev    : 1.0
//==============================================================================
`default_nettype none

module delivery_game_uc
    import delivery_game_pkg::*;
#(
    parameter int MAX_RETRIES = C_MAX_RETRIES,
    parameter int RETRY_W     = C_RETRY_W
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          iniciar,
    input  wire logic          pausa,
    delivery_game_uc_if.master dp
);
    state_t             r_state;
    state_t             w_next;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_next;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               r_falha;
    logic               w_falha_next;
    ctrl_t              r_ctrl;
    logic               w_start;

    edge_detector u_ed_iniciar (
        .clock (clock),
        .reset (reset),
        .sinal (iniciar),
        .pulso (w_start)
    );

`ifdef DELIVERY_GAME_PAUSE_EN
    logic w_pause;
    logic r_origin_espera;
    logic w_origin_next;

    edge_detector u_ed_pausa (
        .clock (clock),
        .reset (reset),
        .sinal (pausa),
        .pulso (w_pause)
    );
`else
    logic w_unused_pausa;
    assign w_unused_pausa = pausa;
`endif

    assign w_retry_inc = r_retry + RETRY_W'(1);

    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        w_falha_next = r_falha;
`ifdef DELIVERY_GAME_PAUSE_EN
        w_origin_next = r_origin_espera;
`endif
        case (r_state)
            INICIAL: begin
                if (w_start) begin
                    w_next       = PREPARA;
                    w_retry_next = '0;
                    w_falha_next = 1'b0;
                end
            end
            PREPARA: begin
                w_retry_next = '0;
                w_falha_next = 1'b0;
                w_next       = PEDE;
            end
            PEDE: w_next = dp.game_over ? FIM : ESPERA;
            ESPERA: begin
                if (dp.game_over) w_next = FIM;
`ifdef DELIVERY_GAME_PAUSE_EN
                else if (w_pause) begin
                    w_next        = PAUSA;
                    w_origin_next = 1'b1;
                end
`endif
                else if (dp.velocity_ready) begin
                    w_next       = JOGA;
                    w_retry_next = '0;
                end
                else if (dp.velocity_timeout) w_next = FALHA;
            end
            FALHA: begin
                if (dp.game_over) w_next = FIM;
                else if (w_retry_inc == RETRY_W'(MAX_RETRIES)) begin
                    // Sensor given up on for now: keep playing on the last velocity
                    w_falha_next = 1'b1;
                    w_retry_next = '0;
                    w_next       = JOGA;
                end else begin
                    w_retry_next = w_retry_inc;
                    w_next       = PEDE;
                end
            end
            JOGA: begin
                if (dp.game_over) w_next = FIM;
`ifdef DELIVERY_GAME_PAUSE_EN
                else if (w_pause) begin
                    w_next        = PAUSA;
                    w_origin_next = 1'b0;
                end
`endif
                else if (dp.end_delay) w_next = PEDE;
            end
            FIM: begin
                if (w_start) begin
                    w_next       = PREPARA;
                    w_retry_next = '0;
                    w_falha_next = 1'b0;
                end
            end
`ifdef DELIVERY_GAME_PAUSE_EN
            PAUSA: begin
                if (w_pause) w_next = r_origin_espera ? ESPERA : JOGA;
            end
`endif
            default: w_next = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= INICIAL;
            r_retry <= '0;
            r_falha <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_next;
            r_falha <= w_falha_next;
            r_ctrl  <= decode_ctrl(w_next);
        end
    end

`ifdef DELIVERY_GAME_PAUSE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_origin_espera <= 1'b0;
        else        r_origin_espera <= w_origin_next;
    end
`endif

    assign dp.zera_fd           = r_ctrl.zera_fd;
    assign dp.reset_ultrasonico = r_ctrl.reset_ultrasonico;
    assign dp.get_velocity      = r_ctrl.get_velocity;
    assign dp.count_map         = r_ctrl.count_map;
    assign dp.reset_delay       = r_ctrl.reset_delay;
    assign dp.conta_delay       = r_ctrl.conta_delay;
    assign dp.reset_timeout     = r_ctrl.reset_timeout;
    assign dp.conta_timeout     = r_ctrl.conta_timeout;
    assign dp.jogando           = r_ctrl.jogando;
    assign dp.fim_jogo          = r_ctrl.fim_jogo;
    assign dp.falha_sensor      = r_falha;
    assign dp.db_estado         = r_state;
endmodule

`default_nettype wire

// File: tb/tb_delivery_game_uc.sv
//==============================================================================
// Module : tb_delivery_game_uc
// Brief  : Directed table plus randomized run against a reference model
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_delivery_game_uc;
    localparam int MAXR = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0;
    logic pausa = 1'b0;
    int   checks = 0;
    int   errors = 0;

    delivery_game_uc_if dp();

    delivery_game_uc #(.MAX_RETRIES(MAXR), .RETRY_W(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .iniciar (iniciar),
        .pausa   (pausa),
        .dp      (dp)
    );

    always #5 clock = ~clock;

    // {zera_fd, reset_ultrasonico, get_velocity, count_map, reset_delay,
    //  conta_delay, reset_timeout, conta_timeout, jogando, fim_jogo}
    function automatic logic [9:0] exp_ctrl(input int s);
        case (s)
            1:       return 10'b1100101000;
            2:       return 10'b0011101010;
            3:       return 10'b0001000110;
            4:       return 10'b0001010010;
            5:       return 10'b0101000010;
            6:       return 10'b0000000001;
            7:       return 10'b0000000010;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [9:0] got_ctrl();
        return {dp.zera_fd, dp.reset_ultrasonico, dp.get_velocity, dp.count_map,
                dp.reset_delay, dp.conta_delay, dp.reset_timeout, dp.conta_timeout,
                dp.jogando, dp.fim_jogo};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int falha);
        check({tag, ".state"}, int'(dp.db_estado), st);
        check({tag, ".ctrl"},  int'(got_ctrl()), int'(exp_ctrl(st)));
        check({tag, ".falha"}, int'(dp.falha_sensor), falha);
    endtask

    task automatic drive(input logic ini, input logic go, input logic vr,
                         input logic vt, input logic ed, input logic p);
        @(negedge clock);
        iniciar             = ini;
        dp.game_over        = go;
        dp.velocity_ready   = vr;
        dp.velocity_timeout = vt;
        dp.end_delay        = ed;
        pausa               = p;
        @(posedge clock);
        #1;
    endtask

    // Reference model: game phase by its documented code, retries, sticky flag
    int   m_st;
    int   m_retries;
    int   m_falha;
    logic m_ini_prev;

    task automatic model_reset();
        m_st = 0; m_retries = 0; m_falha = 0; m_ini_prev = 1'b0;
    endtask

    task automatic model_step(input logic ini, input logic go, input logic vr,
                              input logic vt, input logic ed);
        bit start;
        bit in_game;
        start      = ini && !m_ini_prev;
        m_ini_prev = ini;
        in_game    = (m_st >= 2 && m_st <= 5);
        if (in_game && go) m_st = 6;
        else if ((m_st == 0 || m_st == 6) && start) begin
            m_st = 1; m_retries = 0; m_falha = 0;
        end
        else if (m_st == 1) m_st = 2;
        else if (m_st == 2) m_st = 3;
        else if (m_st == 3 && vr) begin m_st = 4; m_retries = 0; end
        else if (m_st == 3 && vt) m_st = 5;
        else if (m_st == 5) begin
            m_retries++;
            if (m_retries == MAXR) begin m_falha = 1; m_retries = 0; m_st = 4; end
            else m_st = 2;
        end
        else if (m_st == 4 && ed) m_st = 2;
    endtask

    typedef struct {
        logic ini, go, vr, vt, ed;
        int   st;
        int   falha;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ini, input logic go, input logic vr,
                                input logic vt, input logic ed, input int st, input int f);
        vec_t v;
        v.ini = ini; v.go = go; v.vr = vr; v.vt = vt; v.ed = ed; v.st = st; v.falha = f;
        return v;
    endfunction

    initial begin
        //             ini go vr vt ed  st f
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 6, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 6, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4, 0));

        dp.game_over = 1'b0; dp.velocity_ready = 1'b0;
        dp.velocity_timeout = 1'b0; dp.end_delay = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_all("reset", 0, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ini, vecs[i].go, vecs[i].vr, vecs[i].vt, vecs[i].ed, 1'b0);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].falha);
        end

        // Asynchronous reset from JOGA, observed before any clock edge
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 1'b0);
        check_all("rst_hold", 0, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            logic ini, go, vr, vt, ed;
            ini = ($urandom_range(0, 7) == 0) ? ~iniciar : iniciar;
            go  = ($urandom_range(0, 39) == 0);
            vr  = ($urandom_range(0, 5) == 0);
            vt  = ($urandom_range(0, 3) == 0);
            ed  = ($urandom_range(0, 4) == 0);
            drive(ini, go, vr, vt, ed, 1'b0);
            model_step(ini, go, vr, vt, ed);
            check_all($sformatf("rnd%0d", c), m_st, m_falha);
        end

`ifdef DELIVERY_GAME_PAUSE_EN
        drive(0, 0, 0, 0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 1'b0);
        drive(0, 0, 1, 0, 0, 1'b0);
        check_all("p_joga", 4, 0);
        drive(0, 0, 0, 0, 0, 1'b1);
        check_all("p_enter", 7, 0);
        drive(0, 1, 0, 0, 1, 1'b1);
        check_all("p_go_ign", 7, 0);
        drive(0, 0, 0, 0, 0, 1'b0);
        check_all("p_hold", 7, 0);
        drive(0, 0, 0, 0, 0, 1'b1);
        check_all("p_exit", 4, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
